axil_regbank_gen: RTL and testbench

Parametrised AXI4-Lite slave register bank, the next generation of the fixed 4-register slave inside the amb_ahb IP. Depth, data width and read-only mapping are configurable. Supports byte strobes, SLVERR decode and independent AW/W acceptance. Sits between the AXI4-Lite interconnect (VIP master in the BFM design) and user logic, which sees register contents and per-register write pulses.

---
 rtl/axil_regbank_gen.sv | 186 ++++++++++++++++++
 tb/tb_axil_regbank_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/axil_regbank_gen.sv
// axil_regbank_gen: parametrised AXI4-Lite slave register bank with byte strobes, SLVERR decode and read-only mapping
// Ports: S_AXI_ACLK/S_AXI_ARESET clock and async active-high reset; S_AXI_AW*/W*/B* write channels;
//        S_AXI_AR*/R* read channels; reg_out flattened register view (RO slots show reg_in);
//        reg_in sources for read-only registers; wr_pulse one-cycle per-register write strobe.
// Optional AXIL_REGBANK_IRQ_EN: adds hw_event/irq; register NUM_REGS-1 becomes sticky W1C status,
//        register NUM_REGS-2 its interrupt enable.
module axil_regbank_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 8,
  parameter int ADDR_WIDTH = 8,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0
) (
  input  logic                             S_AXI_ACLK,
  input  logic                             S_AXI_ARESET,
  input  logic [ADDR_WIDTH-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                       S_AXI_AWPROT,
  input  logic                             S_AXI_AWVALID,
  output logic                             S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]            S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
  input  logic                             S_AXI_WVALID,
  output logic                             S_AXI_WREADY,
  output logic [1:0]                       S_AXI_BRESP,
  output logic                             S_AXI_BVALID,
  input  logic                             S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                       S_AXI_ARPROT,
  input  logic                             S_AXI_ARVALID,
  output logic                             S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]            S_AXI_RDATA,
  output logic [1:0]                       S_AXI_RRESP,
  output logic                             S_AXI_RVALID,
  input  logic                             S_AXI_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]   reg_in,
  output logic [NUM_REGS-1:0]              wr_pulse
`ifdef AXIL_REGBANK_IRQ_EN
  ,
  input  logic [DATA_WIDTH-1:0]            hw_event,
  output logic                             irq
`endif
);
  localparam int BYTES = DATA_WIDTH/8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int IW = ADDR_WIDTH - ADDR_LSB;
`ifdef AXIL_REGBANK_IRQ_EN
  // status and enable registers are always writable, whatever RO_MASK says
  localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK & ~(NUM_REGS'(3) << (NUM_REGS-2));
`else
  localparam logic [NUM_REGS-1:0] RO_EFF = RO_MASK;
`endif
  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_RESP} r_state_t;
  w_state_t r_wstate;
  r_state_t r_rstate;
  logic r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
  logic [1:0] r_bresp, r_rresp;
  logic [IW-1:0] r_awidx;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
  logic [BYTES-1:0] r_wstrb;
  logic [NUM_REGS-1:0] r_wr_pulse, w_ok;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_view [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_next [NUM_REGS];
  logic [DATA_WIDTH-1:0] w_bmask, w_rdata;
  logic [IW-1:0] w_aridx;
  logic w_rhit, w_aw_hs, w_w_hs, w_aw_have, w_w_have;
  logic w_unused;
  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0], reg_in};
  assign S_AXI_AWREADY = r_awready;
  assign S_AXI_WREADY = r_wready;
  assign S_AXI_BVALID = r_bvalid;
  assign S_AXI_BRESP = r_bresp;
  assign S_AXI_ARREADY = r_arready;
  assign S_AXI_RVALID = r_rvalid;
  assign S_AXI_RDATA = r_rdata;
  assign S_AXI_RRESP = r_rresp;
  assign wr_pulse = r_wr_pulse;
  assign w_aridx = S_AXI_ARADDR[ADDR_WIDTH-1:ADDR_LSB];
  assign w_aw_hs = S_AXI_AWVALID & r_awready;
  assign w_w_hs = S_AXI_WVALID & r_wready;
  // a dropped ready in W_IDLE means that half of the write is already captured
  assign w_aw_have = ~r_awready | S_AXI_AWVALID;
  assign w_w_have = ~r_wready | S_AXI_WVALID;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign w_ok[i] = (r_wstate == W_EXEC) && (r_awidx == IW'(i)) && !RO_EFF[i];
    assign w_view[i] = RO_EFF[i] ? reg_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i];
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = w_view[i];
  end
  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < BYTES; b++) w_bmask[b*8 +: 8] = {8{r_wstrb[b]}};
  end
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) w_next[i] = w_ok[i] ? (r_regs[i] & ~w_bmask) | (r_wdata & w_bmask) : r_regs[i];
`ifdef AXIL_REGBANK_IRQ_EN
    // sticky status: hardware set is applied after the W1C clear so it wins
    w_next[NUM_REGS-1] = (r_regs[NUM_REGS-1] & ~(w_ok[NUM_REGS-1] ? r_wdata & w_bmask : '0)) | hw_event;
`endif
  end
  always_comb begin
    w_rdata = '0;
    w_rhit = 1'b0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_aridx == IW'(i)) begin
        w_rdata = w_view[i];
        w_rhit = 1'b1;
      end
  end
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    else for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= w_next[i];
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) begin
      r_wstate <= W_IDLE;
      r_awready <= 1'b1;
      r_wready <= 1'b1;
      r_bvalid <= 1'b0;
      r_bresp <= 2'b00;
      r_awidx <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= (r_wstate == W_EXEC) ? w_ok : '0;
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awidx <= S_AXI_AWADDR[ADDR_WIDTH-1:ADDR_LSB];
            r_awready <= 1'b0;
          end
          if (w_w_hs) begin
            r_wdata <= S_AXI_WDATA;
            r_wstrb <= S_AXI_WSTRB;
            r_wready <= 1'b0;
          end
          if (w_aw_have && w_w_have) r_wstate <= W_EXEC;
        end
        W_EXEC: begin
          r_bvalid <= 1'b1;
          r_bresp <= (|w_ok) ? 2'b00 : 2'b10;
          r_wstate <= W_RESP;
        end
        W_RESP:
          if (S_AXI_BREADY) begin
            r_bvalid <= 1'b0;
            r_awready <= 1'b1;
            r_wready <= 1'b1;
            r_wstate <= W_IDLE;
          end
        default: r_wstate <= W_IDLE;
      endcase
    end
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) begin
      r_rstate <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid <= 1'b0;
      r_rresp <= 2'b00;
      r_rdata <= '0;
    end else
      case (r_rstate)
        R_IDLE:
          if (S_AXI_ARVALID) begin
            r_rstate <= R_RESP;
            r_arready <= 1'b0;
            r_rvalid <= 1'b1;
            r_rdata <= w_rdata;
            r_rresp <= w_rhit ? 2'b00 : 2'b10;
          end
        R_RESP:
          if (S_AXI_RREADY) begin
            r_rstate <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid <= 1'b0;
          end
        default: r_rstate <= R_IDLE;
      endcase
`ifdef AXIL_REGBANK_IRQ_EN
  logic r_irq;
  assign irq = r_irq;
  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET)
    if (S_AXI_ARESET) r_irq <= 1'b0;
    else r_irq <= |(r_regs[NUM_REGS-1] & r_regs[NUM_REGS-2]);
`endif
endmodule

// File: tb/tb_axil_regbank_gen.sv
// tb_axil_regbank_gen: directed and randomized checks of axil_regbank_gen against an array-based register model
module tb_axil_regbank_gen;
  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 8;
  localparam logic [NR-1:0] RO = 8'h02;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0] awprot, arprot;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [DW-1:0] wdata, rdata;
  logic [DW/8-1:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [NR*DW-1:0] reg_out, reg_in;
  logic [NR-1:0] wr_pulse;
`ifdef AXIL_REGBANK_IRQ_EN
  logic [DW-1:0] hw_event = '0;
  logic irq;
`endif
  int total = 0;
  int bad = 0;
  logic [DW-1:0] model [NR];
  logic [NR-1:0] pulse_log = '0;
  int pulse_tot = 0;
  axil_regbank_gen #(.DATA_WIDTH(DW), .NUM_REGS(NR), .ADDR_WIDTH(AW), .RO_MASK(RO)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .reg_out(reg_out), .reg_in(reg_in), .wr_pulse(wr_pulse)
`ifdef AXIL_REGBANK_IRQ_EN
    , .hw_event(hw_event), .irq(irq)
`endif
  );
  always @(posedge clk) begin
    pulse_log = pulse_log | wr_pulse;
    pulse_tot += $countones(wr_pulse);
  end
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [NR*DW-1:0] exp_out();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = RO[i] ? reg_in[i*DW +: DW] : model[i];
    return v;
  endfunction
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          input int awd_l, input int wd_l, input int bd);
    int idx = int'(a >> 2);
    bit ok = (idx < NR) ? !RO[idx] : 1'b0;
    logic [1:0] er = ok ? 2'b00 : 2'b10;
    logic [DW-1:0] m = '0;
    int c = 0;
    int bseen = -1;
    bit awd = 0, wdn = 0, hs_aw, hs_w;
    awaddr = a; wdata = d; wstrb = s; bready = 0;
    pulse_log = '0; pulse_tot = 0;
    awvalid = (awd_l == 0); wvalid = (wd_l == 0);
    while (bseen < 0 && c < 40) begin
      hs_aw = awvalid && awready;
      hs_w = wvalid && wready;
      @(posedge clk); #1; c++;
      if (hs_aw) begin awd = 1; chk("awready_drop", awready, 0); end
      if (hs_w) begin wdn = 1; chk("wready_drop", wready, 0); end
      awvalid = !awd && c >= awd_l;
      wvalid = !wdn && c >= wd_l;
      if (bvalid) bseen = c;
    end
    awvalid = 0; wvalid = 0;
    chk("bvalid_latency", bseen, (awd_l > wd_l ? awd_l : wd_l) + 2);
    for (int k = 0; k < bd; k++) begin
      chk("b_hold", {bvalid, bresp}, {1'b1, er});
      @(posedge clk); #1;
    end
    chk("bresp", bresp, er);
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    chk("b_done", {bvalid, awready, wready}, 3'b011);
    for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
    if (ok) model[idx] = (model[idx] & ~m) | (d & m);
`ifdef AXIL_REGBANK_IRQ_EN
    if (idx == NR-1) model[idx] = (model[idx] & ~(d & m)) | hw_event;
`endif
    chk("wr_pulse", pulse_log, ok ? NR'(1) << idx : NR'(0));
    chk("wr_pulse_count", pulse_tot, ok ? 1 : 0);
    chk("reg_out", reg_out, exp_out());
  endtask
  task automatic do_read(input logic [AW-1:0] a, input int rd, output logic [DW-1:0] got);
    int idx = int'(a >> 2);
    logic [DW-1:0] ed = (idx < NR) ? (RO[idx] ? reg_in[idx*DW +: DW] : model[idx]) : '0;
    logic [1:0] er = (idx < NR) ? 2'b00 : 2'b10;
    int c = 0;
    bit hs = 0;
    araddr = a; arvalid = 1; rready = 0;
    while (!hs && c < 20) begin
      hs = arvalid && arready;
      @(posedge clk); #1; c++;
    end
    arvalid = 0;
    chk("ar_handshake", hs, 1);
    chk("rvalid_latency", rvalid, 1);
    got = rdata;
    for (int k = 0; k < rd; k++) begin
      chk("r_hold", {rvalid, arready, rresp, rdata}, {2'b10, er, ed});
      @(posedge clk); #1;
    end
    chk("rdata", rdata, ed);
    chk("rresp", rresp, er);
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("r_done", {rvalid, arready}, 2'b01);
  endtask
  initial begin
    logic [DW-1:0] got;
    awaddr = '0; araddr = '0; awprot = '0; arprot = '0; wdata = '0; wstrb = '0;
    awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
    for (int i = 0; i < NR; i++) begin
      model[i] = '0;
      reg_in[i*DW +: DW] = $urandom;
    end
    reg_in[DW +: DW] = 32'hCAFE0001;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready_valid", {awready, wready, arready, bvalid, rvalid}, 5'b11100);
    chk("rst_resp", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 0);
    chk("rst_wr_pulse", wr_pulse, 0);
    chk("rst_reg_out", reg_out, exp_out());
    rst = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) do_write(AW'(i*4), DW'(i+1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(AW'(i*4), 0, got);
    do_read(8'h0, 0, got);
    chk("t1_reg0", got, 32'h1);
    do_read(8'hC, 0, got);
    chk("t1_reg3", got, 32'h4);
    do_write(8'h0, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(8'h0, 32'h11223344, 4'b0101, 0, 0, 0);
    do_read(8'h0, 0, got);
    chk("strobe_merge", got, 32'hAA22CC44);
    do_write(8'h8, 32'h0BADF00D, 4'hF, 0, 5, 3);
    do_write(8'h10, 32'h600DCAFE, 4'hF, 4, 1, 2);
    do_write(8'h20, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(8'h20, 0, got);
    chk("oor_rdata", got, 0);
    do_write(8'h4, 32'h00005555, 4'hF, 0, 0, 0);
    do_read(8'h4, 0, got);
    chk("ro_rdata", got, 32'hCAFE0001);
    do_write(8'hC, 32'hFFFFFFFF, 4'h0, 0, 0, 1);
    do_read(8'h8, 4, got);
    awaddr = 8'h0; wdata = 32'h12345678; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    @(posedge clk); #1;
    chk("pre_reset_bvalid", bvalid, 1);
    chk("pre_reset_reg0", reg_out[DW-1:0], 32'h12345678);
    #2 rst = 1;
    #1;
    for (int i = 0; i < NR; i++) model[i] = '0;
    chk("mid_reset_channels", {bvalid, awready, wready, rvalid}, 4'b0110);
    chk("mid_reset_regs", reg_out, exp_out());
    @(posedge clk); #1;
    rst = 0;
    @(posedge clk); #1;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write(AW'($urandom_range(0, 39)), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read(AW'($urandom_range(0, 39)), $urandom_range(0, 3), got);
    end
`ifdef AXIL_REGBANK_IRQ_EN
    do_write(8'h18, 32'h1, 4'hF, 0, 0, 0);
    do_write(8'h1C, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("irq_idle", irq, 0);
    hw_event = 32'h1;
    @(posedge clk); #1;
    hw_event = '0;
    model[NR-1] = 32'h1;
    chk("status_set", reg_out[(NR-1)*DW +: DW], 32'h1);
    chk("irq_delay", irq, 0);
    @(posedge clk); #1;
    chk("irq_set", irq, 1);
    do_write(8'h1C, 32'h1, 4'hF, 0, 0, 0);
    chk("irq_clear", irq, 0);
    hw_event = 32'h1;
    do_write(8'h1C, 32'h1, 4'hF, 0, 0, 0);
    hw_event = '0;
    chk("set_wins", reg_out[(NR-1)*DW +: DW], 32'h1);
    @(posedge clk); #1;
    chk("irq_after_set_wins", irq, 1);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
